// File: rtl/mp_add_seq_pkg.sv
// mp_add_seq_pkg
//   Shared definitions for the multi-precision add/subtract sequencer:
//   byte width of the adder slice, the sequencer state encoding and the
//   helper that sizes the byte index.
package mp_add_seq_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Byte index width; never narrower than one bit.
   function automatic int idx_w(input int nbytes);
      return (nbytes > 1) ? $clog2(nbytes) : 1;
   endfunction

endpackage

// File: rtl/mp_add_seq_adder.sv
// adder
//   8-bit carry-lookahead adder slice.
//   Ports:
//     A, B  : 8-bit operands
//     Cin   : carry in
//     Cout  : carry out of bit 7
//     sum   : 8-bit sum
module adder (
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Cin,
   output logic       Cout,
   output logic [7:0] sum
);

   logic [7:0] g;
   logic [7:0] p;
   logic [8:0] c;

   assign g = A & B;
   assign p = A ^ B;

   // Every carry is a flat sum of products of generate/propagate terms,
   // so no carry depends on another carry net.
   always_comb begin
      logic cy;
      logic pr;
      c = '0;
      for (int i = 0; i <= 8; i++) begin
         cy = 1'b0;
         pr = 1'b1;
         for (int j = i - 1; j >= 0; j--) begin
            cy = cy | (pr & g[j]);
            pr = pr & p[j];
         end
         c[i] = cy | (pr & Cin);
      end
   end

   assign sum  = p ^ c[7:0];
   assign Cout = c[8];

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq
//   Multi-precision add/subtract sequencer. One 8-bit adder slice is run
//   over NBYTES cycles, least-significant byte first, with the carry chained
//   through a register.
//   Parameters:
//     NBYTES   : operand width in bytes (2..16)
//   Ports:
//     clk      : rising-edge clock
//     rst      : synchronous active-high reset
//     start    : operation request, sampled only when not busy
//     op_sub   : 0 = a+b, 1 = a-b, sampled with start
//     a, b     : operands, sampled with start
//     busy     : high while bytes are being processed
//     done     : one-cycle pulse when result/cout/overflow are valid
//     result   : sum/difference, held until the next accepted start
//     cout     : final carry out (subtract: 1 = no borrow)
//     overflow : signed overflow, only built when MP_ADD_SEQ_OVF_EN is
//                defined; otherwise tied to 0
module mp_add_seq
   import mp_add_seq_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     op_sub,
   input  logic [BYTE_W*NBYTES-1:0] a,
   input  logic [BYTE_W*NBYTES-1:0] b,
   output logic                     busy,
   output logic                     done,
   output logic [BYTE_W*NBYTES-1:0] result,
   output logic                     cout,
   output logic                     overflow
);

   localparam int             W    = BYTE_W * NBYTES;
   localparam int             IW   = idx_w(NBYTES);
   localparam logic [IW-1:0]  LAST = IW'(NBYTES - 1);

   state_t              state, state_nxt;
   logic [W-1:0]        opa;
   logic [W-1:0]        opb;
   logic                carry;
   logic [IW-1:0]       idx;
   logic [BYTE_W-1:0]   sa, sb, sum;
   logic                sc;
   logic                accept;
   logic                last;

   // start is only honoured outside RUN, which includes the DONE cycle
   assign accept = start && (state != RUN);
   assign last   = (state == RUN) && (idx == LAST);

   // Byte slice feeding the adder
   assign sa = opa[idx*BYTE_W +: BYTE_W];
   assign sb = opb[idx*BYTE_W +: BYTE_W];

   adder u_adder (
      .A   (sa),
      .B   (sb),
      .Cin (carry),
      .Cout(sc),
      .sum (sum)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode straight from the state register
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Datapath: subtract is a + ~b + 1, so b is inverted on capture and the
   // carry is seeded with op_sub.
   always_ff @(posedge clk) begin
      if (rst) begin
         opa    <= '0;
         opb    <= '0;
         carry  <= 1'b0;
         idx    <= '0;
         result <= '0;
         cout   <= 1'b0;
      end else if (accept) begin
         opa    <= a;
         opb    <= op_sub ? ~b : b;
         carry  <= op_sub;
         idx    <= '0;
         result <= '0;
         cout   <= 1'b0;
      end else if (state == RUN) begin
         result[idx*BYTE_W +: BYTE_W] <= sum;
         carry <= sc;
         if (last) cout <= sc;
         else      idx  <= idx + 1'b1;
      end
   end

`ifdef MP_ADD_SEQ_OVF_EN
   // Sign bits of the top byte decide overflow; sb is already inverted
   // for subtract, so one rule covers both operations.
   always_ff @(posedge clk) begin
      if (rst)
         overflow <= 1'b0;
      else if (accept)
         overflow <= 1'b0;
      else if (last)
         overflow <= (sa[BYTE_W-1] == sb[BYTE_W-1]) &&
                     (sum[BYTE_W-1] != sa[BYTE_W-1]);
   end
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq
//   Scoreboard bench for mp_add_seq with NBYTES=4. Accepted starts push the
//   expected result into a queue; a negedge monitor pops on every done and
//   also checks busy against the expected RUN window.
module tb_mp_add_seq;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         op_sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, cout, overflow;
   logic [W-1:0] result;

   mp_add_seq #(.NBYTES(NB)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op_sub  (op_sub),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .cout    (cout),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   cyc      = 0;
   int   run_from = -100;
   int   n_vec    = 0;
   int   n_err    = 0;
   bit   chk_en   = 1'b0;

   // count of rising edges seen so far
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the full-width operands
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input bit sub);
      exp_t         e;
      logic [W:0]   full;
      longint       sx, sy, r, lim;
      if (!sub) begin
         full   = {1'b0, x} + {1'b0, y};
         e.res  = full[W-1:0];
         e.cout = full[W];
      end else begin
         e.res  = x - y;
         e.cout = (x >= y);
      end
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      r   = sub ? (sx - sy) : (sx + sy);
      lim = longint'(1) <<< (W - 1);
`ifdef MP_ADD_SEQ_OVF_EN
      e.ovf = (r >= lim) || (r < -lim);
`else
      e.ovf = 1'b0;
`endif
      e.cyc = 0;
      return e;
   endfunction

   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Called at a negedge; drives start for one cycle. If acc is set the
   // start is expected to be taken at the next edge (edge count cyc+1) and
   // done is seen in the cycle that begins NB edges after that.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit sub, input bit acc);
      exp_t e;
      a      = x;
      b      = y;
      op_sub = sub;
      start  = 1'b1;
      if (acc) begin
         e        = model(x, y, sub);
         e.cyc    = cyc + 1 + NB;
         run_from = cyc + 1;
         sbq.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // Issue one accepted op and return at the negedge of its DONE cycle.
   // inj adds an ignored start with different operands inside RUN.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit sub, input bit inj);
      issue(x, y, sub, 1'b1);
      if (inj) begin
         wait_n(1);
         issue($urandom, $urandom, ~sub, 1'b0);
         wait_n(NB - 2);
      end else begin
         wait_n(NB);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, (cyc >= run_from) && (cyc < run_from + NB));
         if (done === 1'b1) begin
            if (sbq.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_done: done=1 at cycle %0d, expected no done", cyc);
            end else begin
               mon_e = sbq.pop_front();
               chk("done_cycle", cyc, mon_e.cyc);
               chk("result", result, mon_e.res);
               chk("cout", cout, mon_e.cout);
               chk("overflow", overflow, mon_e.ovf);
            end
         end else if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_done: no done by cycle %0d, expected at %0d", cyc, sbq[0].cyc);
            void'(sbq.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] x, y;
      // reset state
      rst = 1'b1;
      wait_n(2);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_cout", cout, 0);
      chk("rst_overflow", overflow, 0);
      rst    = 1'b0;
      chk_en = 1'b1;

      // directed cases
      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      wait_n(1);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);   // back-to-back
      run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0);
      wait_n(2);
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
      wait_n(1);
      run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);   // ignored start in RUN
      run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);   // start during DONE
      wait_n(1);

      // reset in the middle of RUN (idx=2), with start also high
      issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1);
      wait_n(2);
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      sbq.delete();
      run_from = -100;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_result", result, 0);
      chk("abort_done", done, 0);
      chk("abort_cout", cout, 0);
      chk("abort_overflow", overflow, 0);
      wait_n(1);
      run_op(32'h0000_1000, 32'h0000_0FFF, 1'b1, 1'b0);

      // randomized ops with random gaps, edge-biased operands
      for (int i = 0; i < 40; i++) begin
         wait_n($urandom_range(0, 2));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 5))
            0: x = 32'h7FFF_FFFF;
            1: x = 32'h8000_0000;
            2: y = 32'hFFFF_FFFF;
            3: y = x;
            default: ;
         endcase
         run_op(x, y, 1'(($urandom % 2)), ($urandom % 4) == 0);
      end

      wait_n(NB + 2);
      chk("queue_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
